// File: rtl/uart_rx_fsm.sv
// UART receive control FSM: frame sequencing, bit/edge counters and checker enables.
// Optional parity support is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic [5:0] Prescale,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic [4:0] edge_count,
    output logic [3:0] bit_count,
    output logic       dat_samp_en,
    output logic       deser_en,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid,
    output logic       frame_err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif

    logic [2:0] state_q, state_d;
    logic [4:0] edge_q, edge_d;
    logic [3:0] bit_q, bit_d;
    logic [5:0] ps_q, ps_d;
    logic       dv_q, dv_d;
    logic       fe_q, fe_d;
    logic       par_bad;
    logic       eob;

`ifdef UART_RX_PARITY_EN
    logic par_flag_q, par_flag_d;
    assign par_bad = par_flag_q;
`else
    logic unused_par;
    assign unused_par = PAR_EN ^ par_err;
    assign par_bad    = 1'b0;
`endif

    assign eob = (state_q != IDLE) && ({1'b0, edge_q} == ps_q - 6'd1);

    always_comb begin
        state_d = state_q;
        edge_d  = 5'd0;
        bit_d   = bit_q;
        ps_d    = ps_q;
        dv_d    = 1'b0;
        fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_flag_d = par_flag_q;
`endif
        if (state_q != IDLE)
            edge_d = eob ? 5'd0 : edge_q + 5'd1;

        case (state_q)
            IDLE: begin
                bit_d = 4'd0;
`ifdef UART_RX_PARITY_EN
                par_flag_d = 1'b0;
`endif
                if (!RX_IN) begin
                    state_d = START;
                    // Out-of-range prescale falls back to 8x oversampling.
                    ps_d = (Prescale >= 6'd4 && Prescale <= 6'd32) ? Prescale : 6'd8;
                end
            end
            START: if (eob) begin
                if (strt_glitch) begin
                    state_d = IDLE;
                    fe_d    = 1'b1;
                end else begin
                    state_d = DATA;
                    bit_d   = 4'd1;
                end
            end
            DATA: if (eob) begin
                bit_d = bit_q + 4'd1;
                if (bit_q == 4'd8) begin
`ifdef UART_RX_PARITY_EN
                    state_d = PAR_EN ? PARITY : STOP;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (eob) begin
                bit_d      = bit_q + 4'd1;
                par_flag_d = par_err;
                state_d    = STOP;
            end
`endif
            STOP: if (eob) begin
                state_d = IDLE;
                bit_d   = 4'd0;
                dv_d    = !stp_err && !par_bad;
                fe_d    = stp_err || par_bad;
            end
            default: begin
                state_d = IDLE;
                bit_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            edge_q  <= 5'd0;
            bit_q   <= 4'd0;
            ps_q    <= 6'd0;
            dv_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            edge_q  <= edge_d;
            bit_q   <= bit_d;
            ps_q    <= ps_d;
            dv_q    <= dv_d;
            fe_q    <= fe_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) par_flag_q <= 1'b0;
        else      par_flag_q <= par_flag_d;
    end
    assign par_chk_en = (state_q == PARITY);
`else
    assign par_chk_en = 1'b0;
`endif

    assign edge_count  = edge_q;
    assign bit_count   = bit_q;
    assign dat_samp_en = (state_q != IDLE);
    assign deser_en    = (state_q == DATA);
    assign strt_chk_en = (state_q == START);
    assign stp_chk_en  = (state_q == STOP);
    assign data_valid  = dv_q;
    assign frame_err   = fe_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: per-cycle frame model, pulse timing, reset abort, back-to-back.
// Parity expectations follow UART_RX_PARITY_EN the same way the design does.
module tb_uart_rx_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic       strt_glitch = 1'b0;
    logic       par_err = 1'b0;
    logic       stp_err = 1'b0;
    logic [4:0] edge_count;
    logic [3:0] bit_count;
    logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
    logic       data_valid, frame_err;

`ifdef UART_RX_PARITY_EN
    localparam bit PB = 1'b1;
`else
    localparam bit PB = 1'b0;
`endif

    int n_chk = 0;
    int n_err = 0;
    int last_lat;
    int deser_cnt;

    uart_rx_fsm dut (
        .clk(clk), .rst(rst), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .Prescale(Prescale),
        .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
        .edge_count(edge_count), .bit_count(bit_count), .dat_samp_en(dat_samp_en),
        .deser_en(deser_en), .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en),
        .stp_chk_en(stp_chk_en), .data_valid(data_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {edge_count, bit_count, dat_samp_en, deser_en, strt_chk_en,
                par_chk_en, stp_chk_en, data_valid, frame_err};
    endfunction

    task automatic idle(input int n);
        RX_IN = 1'b1; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle", outs(), 32'h0);
        end
    endtask

    // Called at a negedge while the DUT is in IDLE. Error inputs are driven
    // asserted outside their own state so only the EOB sample can matter.
    task automatic frame(input logic [5:0] ps_in, input logic [7:0] d, input bit pe,
                         input bit perr, input bit serr, input bit glitch, input int abort_c);
        int ps, T, s, e, ph, bc, w;
        bit pe_eff;
        logic dv_exp;
        logic [15:0] ex;
        ps     = (ps_in >= 4 && ps_in <= 32) ? int'(ps_in) : 8;
        pe_eff = pe && PB;
        T      = (glitch ? 1 : (pe_eff ? 11 : 10)) * ps;
        Prescale = ps_in; PAR_EN = pe; RX_IN = 1'b0;
        strt_glitch = 1'b1; par_err = 1'b1; stp_err = 1'b1;
        deser_cnt = 0;
        for (int c = 0; c < T; c++) begin
            @(negedge clk);
            s = c / ps; e = c % ps;
            if (s == 0)                 ph = 0;
            else if (s <= 8)            ph = 1;
            else if (pe_eff && s == 9)  ph = 2;
            else                        ph = 3;
            if (ph == 0)      bc = 0;
            else if (ph == 1) bc = s;
            else if (ph == 2) bc = 9;
            else              bc = pe_eff ? 10 : 9;
            ex = {5'(e), 4'(bc), 1'b1, ph == 1, ph == 0, ph == 2, ph == 3, 2'b00};
            chk($sformatf("cyc%0d_ps%0d", c, ps), outs(), ex);
            deser_cnt += int'(deser_en);
            if (c == abort_c) begin
                rst = 1'b0;
                #1;
                chk("abort_outs", outs(), 32'h0);
                return;
            end
            if (c == 0) Prescale = 6'($urandom_range(0, 63));
            if (ph == 0)      RX_IN = 1'b0;
            else if (ph == 1) RX_IN = d[s-1];
            else if (ph == 2) RX_IN = (^d) ^ perr;
            else              RX_IN = 1'b1;
            strt_glitch = (ph == 0) ? glitch : 1'b1;
            par_err     = (ph == 2) ? perr   : 1'b1;
            stp_err     = (ph == 3) ? serr   : 1'b1;
        end
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(data_valid || frame_err) && w < 4);
        last_lat = T + w;
        chk("pulse_lat", last_lat, T + 1);
        dv_exp = !glitch && !serr && !(pe_eff && perr);
        chk("pulse", outs(), {14'h0, dv_exp, !dv_exp});
        RX_IN = 1'b1; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_outs", outs(), 32'h0);
        rst = 1'b1;
        idle(3);

        frame(6'd8, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        chk("a5_lat81", last_lat, 81);
        chk("a5_deser64", deser_cnt, 64);
        idle(2);

        frame(6'd16, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        idle(2);
        frame(6'd8, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        idle(2);

        frame(6'd8, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        chk("glitch_no_deser", deser_cnt, 0);
        idle(2);

        frame(6'd4, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        idle(1);
        frame(6'd32, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle(1);
        frame(6'd3, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        idle(1);
        frame(6'd40, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle(1);

        frame(6'd32, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 4 * 32 + 10);
        RX_IN = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("in_reset", outs(), 32'h0);
        end
        rst = 1'b1;
        idle(4);
        frame(6'd32, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle(1);

        frame(6'd8, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        frame(6'd8, 8'h34, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
